// File: rtl/s2_pkg.sv
// Shared encodings, field offsets and FSM states for the S2 cell array.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package s2_pkg;

   // Gate function encodings used by both select bits
   localparam logic [1:0] FN_AND   = 2'b00;
   localparam logic [1:0] FN_OR    = 2'b01;
   localparam logic [1:0] FN_XOR   = 2'b10;
   localparam logic [1:0] FN_PASSA = 2'b11;

   // Per-lane configuration word layout
   localparam int CFG_W      = 5;
   localparam int FN0_LSB    = 0;
   localparam int FN1_LSB    = 2;
   localparam int BYPASS_BIT = 4;

   // Legacy S2: sel0 = a0 & b0, sel1 = a1 | b1, registered output
   localparam logic [CFG_W-1:0] CFG_RESET = 5'b0_01_00;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   // Evaluate one configurable two-input gate
   function automatic logic gate_fn(input logic [1:0] fn, input logic a, input logic b);
      logic r;
      case (fn)
         FN_AND:  r = a & b;
         FN_OR:   r = a | b;
         FN_XOR:  r = a ^ b;
         default: r = a;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/s2_lane.sv
// One lane: gate-derived 2-bit select, 4:1 word mux, ce-gated register, optional bypass.
// Latency: 1 cycle when registered, 0 cycles when bypassed.
// Backpressure: none; ce only holds the register, the mux is always live.
module s2_lane
   import s2_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic                 clk,
   input  logic                 clr_n,
   input  logic                 ce,
   input  logic [4*WIDTH-1:0]   d,
   input  logic                 a0,
   input  logic                 b0,
   input  logic                 a1,
   input  logic                 b1,
   input  logic [CFG_W-1:0]     cfg,
   output logic [WIDTH-1:0]     out
);

   logic [1:0]       sel;
   logic [WIDTH-1:0] mux_out;
   logic [WIDTH-1:0] out_reg;

   // Select bits from the configured gates, then pick the matching data word
   always_comb begin
      sel[0] = gate_fn(cfg[FN0_LSB +: 2], a0, b0);
      sel[1] = gate_fn(cfg[FN1_LSB +: 2], a1, b1);
      case (sel)
         2'b00:   mux_out = d[0*WIDTH +: WIDTH];
         2'b01:   mux_out = d[1*WIDTH +: WIDTH];
         2'b10:   mux_out = d[2*WIDTH +: WIDTH];
         default: mux_out = d[3*WIDTH +: WIDTH];
      endcase
   end

   // Output register keeps tracking mux_out even while bypassed
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         out_reg <= '0;
      end else if (ce) begin
         out_reg <= mux_out;
      end
   end

   assign out = cfg[BYPASS_BIT] ? mux_out : out_reg;

endmodule

// File: rtl/s2_cell_array.sv
// CHANNELS S2 lanes with serially loaded, atomically committed per-lane configuration.
// Latency: lanes 1 cycle (registered) or 0 (bypass); config takes effect the edge after COMMIT.
// Backpressure: cfg_ready gates bit acceptance; cfg_valid gaps stall the load indefinitely.
module s2_cell_array
   import s2_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 1
) (
   input  logic                    clk,
   input  logic                    clr_n,
   input  logic                    ce,
   input  logic [CHANNELS*4*WIDTH-1:0] d,
   input  logic [CHANNELS-1:0]     a0,
   input  logic [CHANNELS-1:0]     b0,
   input  logic [CHANNELS-1:0]     a1,
   input  logic [CHANNELS-1:0]     b1,
   input  logic                    cfg_start,
   input  logic                    cfg_valid,
   input  logic                    cfg_bit,
   output logic                    cfg_ready,
   output logic                    cfg_done,
   output logic                    cfg_err,
   output logic [CHANNELS*WIDTH-1:0] out
);

   localparam int CFG_BITS = CFG_W * CHANNELS;
   localparam int CNT_W    = $clog2(CFG_BITS + 1);

   state_t               state;
   state_t               state_nxt;
   logic                 ready_q;
   logic [CNT_W-1:0]     cnt;
   logic [CFG_BITS-1:0]  shadow;
   logic [CFG_BITS-1:0]  active;
   logic                 accept;
   logic                 last_bit;

   // A restart in LOAD discards any bit offered in the same cycle
   assign accept   = (state == ST_LOAD) && cfg_valid && !cfg_start;
   assign last_bit = accept && (cnt == CNT_W'(CFG_BITS - 1));

   // State register; cfg_ready is flopped alongside so it is glitch-free
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state   <= ST_IDLE;
         ready_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         ready_q <= (state_nxt == ST_LOAD);
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (cfg_start) state_nxt = ST_LOAD;
         ST_LOAD:   if (last_bit)  state_nxt = ST_COMMIT;
         ST_COMMIT: state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Handshake outputs decoded from the current state
   always_comb begin
      cfg_ready = ready_q;
      cfg_done  = (state == ST_COMMIT);
      cfg_err   = (state == ST_LOAD) && cfg_start;
   end

   // Bit counter and shadow shift register; first bit ends up at shadow[0]
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         cnt    <= '0;
         shadow <= '0;
      end else if (cfg_start && (state != ST_COMMIT)) begin
         cnt <= '0;
      end else if (accept) begin
         shadow <= {cfg_bit, shadow[CFG_BITS-1:1]};
         cnt    <= last_bit ? '0 : cnt + CNT_W'(1);
      end
   end

   // Active configuration only changes in COMMIT, so lanes never see partial data
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         active <= {CHANNELS{CFG_RESET}};
      end else if (state == ST_COMMIT) begin
         active <= shadow;
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
      s2_lane #(
         .WIDTH (WIDTH)
      ) u_lane (
         .clk   (clk),
         .clr_n (clr_n),
         .ce    (ce),
         .d     (d[c*4*WIDTH +: 4*WIDTH]),
         .a0    (a0[c]),
         .b0    (b0[c]),
         .a1    (a1[c]),
         .b1    (b1[c]),
         .cfg   (active[c*CFG_W +: CFG_W]),
         .out   (out[c*WIDTH +: WIDTH])
      );
   end

endmodule

// File: tb/tb_s2_cell_array.sv
// Self-checking bench for s2_cell_array against a cycle-level behavioural model.
// Latency: model mirrors 1-cycle registered / 0-cycle bypass lane timing.
// Backpressure: bench drives cfg_valid with and without gaps.
module tb_s2_cell_array;

   localparam int CH   = 4;
   localparam int W    = 8;
   localparam int NB   = 5 * CH;
   localparam logic [4:0] DEF_CFG = 5'b0_01_00;

   logic              clk;
   logic              clr_n;
   logic              ce;
   logic [CH*4*W-1:0] d;
   logic [CH-1:0]     a0, b0, a1, b1;
   logic              cfg_start, cfg_valid, cfg_bit;
   logic              cfg_ready, cfg_done, cfg_err;
   logic [CH*W-1:0]   out;

   int n_checks;
   int n_errors;
   int done_seen;
   bit hold_data;
   int ce_mode;   // 0/1 fixed ce, 2 random

   // Behavioural model state
   logic [4:0]   m_act [CH];
   logic [W-1:0] m_reg [CH];
   bit           m_loading;
   bit           m_commit;
   bit           m_bits[$];

   s2_cell_array #(
      .CHANNELS (CH),
      .WIDTH    (W)
   ) dut (
      .clk       (clk),
      .clr_n     (clr_n),
      .ce        (ce),
      .d         (d),
      .a0        (a0),
      .b0        (b0),
      .a1        (a1),
      .b1        (b1),
      .cfg_start (cfg_start),
      .cfg_valid (cfg_valid),
      .cfg_bit   (cfg_bit),
      .cfg_ready (cfg_ready),
      .cfg_done  (cfg_done),
      .cfg_err   (cfg_err),
      .out       (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic gate(input logic [1:0] fn, input logic a, input logic b);
      if (fn == 2'd0) return a & b;
      if (fn == 2'd1) return a | b;
      if (fn == 2'd2) return a ^ b;
      return a;
   endfunction

   function automatic logic [W-1:0] mux_word(input int c);
      int sel;
      sel = 2 * int'(gate(m_act[c][3:2], a1[c], b1[c])) + int'(gate(m_act[c][1:0], a0[c], b0[c]));
      return d[c*4*W + sel*W +: W];
   endfunction

   function automatic logic [CH*W-1:0] exp_out();
      logic [CH*W-1:0] e;
      e = '0;
      for (int c = 0; c < CH; c++)
         e[c*W +: W] = m_act[c][4] ? mux_word(c) : m_reg[c];
      return e;
   endfunction

   task automatic m_reset();
      for (int c = 0; c < CH; c++) begin
         m_act[c] = DEF_CFG;
         m_reg[c] = '0;
      end
      m_loading = 0;
      m_commit  = 0;
      m_bits.delete();
   endtask

   always @(negedge clr_n) m_reset();

   // Model update at each rising edge: lanes capture under the old config, then protocol advances
   always @(posedge clk) begin
      if (clr_n === 1'b1) begin
         if (ce) for (int c = 0; c < CH; c++) m_reg[c] = mux_word(c);
         if (m_commit) begin
            for (int i = 0; i < NB; i++) m_act[i / 5][i % 5] = m_bits[i];
            m_commit = 0;
         end else if (m_loading) begin
            if (cfg_start) m_bits.delete();
            else if (cfg_valid) begin
               m_bits.push_back(cfg_bit);
               if (m_bits.size() == NB) begin
                  m_loading = 0;
                  m_commit  = 1;
               end
            end
         end else if (cfg_start) begin
            m_loading = 1;
            m_bits.delete();
         end
      end
   end

   task automatic check_all();
      chk("out", out, exp_out());
      chk("cfg_ready", cfg_ready, m_loading);
      chk("cfg_done", cfg_done, m_commit);
      chk("cfg_err", cfg_err, m_loading && cfg_start);
      if (cfg_done) done_seen++;
   endtask

   // One bench cycle: drive at the falling edge, check after settling
   task automatic cyc(input logic st, input logic vl, input logic bt);
      @(negedge clk);
      if (!hold_data) begin
         d  = {$urandom(), $urandom(), $urandom(), $urandom()};
         a0 = CH'($urandom()); b0 = CH'($urandom());
         a1 = CH'($urandom()); b1 = CH'($urandom());
      end
      ce = (ce_mode == 2) ? 1'($urandom()) : 1'(ce_mode);
      cfg_start = st;
      cfg_valid = vl;
      cfg_bit   = bt;
      #1 check_all();
   endtask

   task automatic load_cfg(input logic [NB-1:0] cfg, input int gap);
      done_seen = 0;
      cyc(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < NB; i++) begin
         if (gap > 0 && (i % 2) == 1)
            for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 1'($urandom()));
         cyc(1'b0, 1'b1, cfg[i]);
      end
      cyc(1'b0, 1'b0, 1'b0);   // commit cycle
      chk("done_once", done_seen, 1);
   endtask

   logic [NB-1:0] cfg_a;
   logic [NB-1:0] cfg_b;

   initial begin
      n_checks = 0; n_errors = 0; done_seen = 0;
      hold_data = 0; ce_mode = 1;
      clr_n = 1'b0; ce = 1'b1; d = '0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      cfg_start = 0; cfg_valid = 0; cfg_bit = 0;
      m_reset();
      #12;
      chk("rst_out", out, 0);
      chk("rst_ready", cfg_ready, 0);
      chk("rst_done", cfg_done, 0);
      chk("rst_err", cfg_err, 0);
      @(negedge clk); clr_n = 1'b1;

      // Legacy: a0=b0=1 (AND=1), a1=b1=0 (OR=0) selects D01
      hold_data = 1;
      d = '0; d[1*W +: W] = 8'hA5;
      a0 = 4'b0001; b0 = 4'b0001; a1 = '0; b1 = '0;
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      chk("legacy_d01", out[W-1:0], 8'hA5);
      #1 clr_n = 1'b0;
      #1 chk("async_clr", out, 0);
      @(negedge clk); #2 clr_n = 1'b1;
      hold_data = 0;

      // Random traffic under default config
      for (int i = 0; i < 40; i++) cyc(0, 0, 0);

      // Lane0: fn0=XOR, fn1=PASSA, bypass=1; others default
      cfg_a = {DEF_CFG, DEF_CFG, DEF_CFG, 5'b1_11_10};
      load_cfg(cfg_a, 0);
      hold_data = 1;
      d = {CH{32'h44_33_22_11}};
      a0 = 4'b0001; b0 = 4'b0000; a1 = 4'b0001; b1 = 4'b0000;
      cyc(0, 0, 0);
      chk("byp_d11", out[W-1:0], 8'h44);
      hold_data = 0;
      for (int i = 0; i < 10; i++) cyc(0, 0, 0);

      // Revert, then reload the same config with valid gaps
      load_cfg({CH{DEF_CFG}}, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0);
      load_cfg(cfg_a, 3);
      hold_data = 1;
      d = {CH{32'h44_33_22_11}};
      a0 = 4'b0001; b0 = 4'b0000; a1 = 4'b0001; b1 = 4'b0000;
      cyc(0, 0, 0);
      chk("gap_byp_d11", out[W-1:0], 8'h44);
      hold_data = 0;

      // Restart after 7 bits, then a full random load
      cfg_b = NB'({$urandom(), $urandom()});
      cyc(1, 0, 0);
      for (int i = 0; i < 7; i++) cyc(0, 1, 1'($urandom()));
      cyc(1, 1, 1);
      chk("restart_err", cfg_err, 1);
      chk("restart_ready", cfg_ready, 1);
      done_seen = 0;
      for (int i = 0; i < NB; i++) cyc(0, 1, cfg_b[i]);
      cyc(0, 0, 0);
      chk("restart_done", done_seen, 1);
      for (int i = 0; i < 20; i++) cyc(0, 0, 0);

      // Reset after 10 bits of a load
      cyc(1, 0, 0);
      for (int i = 0; i < 10; i++) cyc(0, 1, 1'($urandom()));
      #1 clr_n = 1'b0;
      #1 chk("midload_rst_ready", cfg_ready, 0);
      chk("midload_rst_out", out, 0);
      @(negedge clk); #2 clr_n = 1'b1;
      for (int i = 0; i < 10; i++) cyc(0, 0, 0);

      // Mixed bypass/registered lanes with ce toggling
      load_cfg({5'b0_10_01, 5'b1_00_11, 5'b0_11_10, 5'b1_01_00}, 0);
      ce_mode = 2;
      for (int i = 0; i < 60; i++) cyc(0, 0, 0);
      ce_mode = 0;
      for (int i = 0; i < 5; i++) cyc(0, 0, 0);
      ce_mode = 2;
      for (int i = 0; i < 20; i++) cyc(0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/s2_cell_array.md
# s2_cell_array

Parametrised, runtime-configurable successor to the single-bit S2 logic cell. CHANNELS independent lanes each hold a 4:1 mux of WIDTH-bit words. Each lane's select bits come from configurable gate functions of its A/B inputs, and its output is either registered or bypassed. Lane configuration is loaded through a serial, handshaked chain and committed atomically. The reset configuration reproduces legacy S2 behaviour.

## Interface
- CHANNELS, 4, number of lanes (≥1)
- WIDTH, 1, data word width per lane (≥1)
- clk  in  1  rising-edge clock
- clr_n  in  1  asynchronous, active-low reset
- ce  in  1  output-register enable, common to all lanes
- d  in  CHANNELS*4*WIDTH  lane c occupies bits [c*4*WIDTH +: 4*WIDTH]; within a lane, D00 is lowest, then D01, D10, D11
- a0, b0, a1, b1  in  CHANNELS  per-lane select operands, bit c belongs to lane c
- cfg_start  in  1  begin a configuration load
- cfg_valid  in  1  cfg_bit is valid this cycle
- cfg_bit  in  1  serial configuration data
- cfg_ready  out  1  load in progress; a bit is accepted when cfg_valid & cfg_ready
- cfg_done  out  1  one-cycle pulse in the commit cycle
- cfg_err  out  1  one-cycle pulse when a load is restarted
- out  out  CHANNELS*WIDTH  lane c at [c*WIDTH +: WIDTH]

## Operation
- Per-lane configuration word is CFG_W=5 bits:
  - [1:0] fn0: sel[0] = fn0(a0,b0)
  - [3:2] fn1: sel[1] = fn1(a1,b1)
  - [4] bypass
- Function encoding: 00 AND, 01 OR, 10 XOR, 11 pass a.
- Mux selection: sel 00 selects D00, 01 selects D01, 10 selects D10, 11 selects D11.
- Output register: on ce, the lane register loads mux_out; otherwise it holds.
- bypass=0: out = register. bypass=1: out = mux_out (combinational). The register keeps updating in both modes.
- Active config after reset, all lanes: fn0=AND, fn1=OR, bypass=0. This is legacy S2 behaviour.
- Shadow config: CHANNELS*5 bits, loaded serially. Lane 0 is first; each lane is LSB first. Total CFG_BITS = 5*CHANNELS.
- FSM states IDLE, LOAD, COMMIT:
  - IDLE: cfg_start moves to LOAD, bit counter is cleared.
  - LOAD: cfg_ready=1. Each accepted bit shifts into shadow and increments the counter. Accepting bit CFG_BITS-1 moves to COMMIT.
  - LOAD with cfg_start high (with or without cfg_valid): counter cleared, any bit this cycle is discarded, cfg_err pulses, FSM stays in LOAD. Shadow contents are don't-care until fully reloaded.
  - COMMIT: cfg_done=1, cfg_ready=0. At the clock edge, active config is loaded from shadow; next state is IDLE. cfg_start in this cycle is ignored.
- The active config never changes except in COMMIT. Lanes keep running on the old config throughout LOAD.
- Reset mid-load: FSM returns to IDLE, active config returns to the default, shadow and counter are cleared, all partial load data is lost.
- Counter width is $clog2(CFG_BITS+1). It never exceeds CFG_BITS-1.

## Timing
- Reset values: out=0 (register cleared; bypass=0 after reset), cfg_ready=0, cfg_done=0, cfg_err=0, state IDLE.
- Registered lane: latency 1 cycle from d/a/b to out. Bypass lane: latency 0.
- cfg_start sampled at edge k: cfg_ready=1 from cycle k+1.
- Last bit accepted at edge m:
  - COMMIT occupies cycle m→m+1, with cfg_done high in that cycle.
  - New config drives mux_out from edge m+1.
  - The first register capture under the new config is edge m+2.
- Minimum load time is CFG_BITS+2 cycles (start, CFG_BITS bits, commit). cfg_valid gaps stall the load without limit.
- cfg_ready is a registered output, derived only from the state.

## Structure
- Package s2_pkg holds:
  - fn encodings (FN_AND, FN_OR, FN_XOR, FN_PASSA)
  - CFG_W=5
  - field offsets
  - CFG_RESET=5'b0_01_00
  - state enum
- Sub-module s2_lane (parameter WIDTH) contains select logic, the mux, the register with ce and clr_n, and bypass. The top instantiates it CHANNELS times in a generate loop.
- The FSM, counter, shadow and active config live in the top.

## Test plan
- Reset defaults, CHANNELS=4, WIDTH=1, ce=1, lane0 inputs a0=b0=1, a1=b1=0, D01=1, others 0 → out[0]=1 one cycle later; clr_n low mid-run forces out=0 immediately.
- Load lane0 fn0=XOR, fn1=PASSA, bypass=1, others default; 20 bits, cfg_done pulses once → with a0=1, b0=0, a1=1, lane0 selects D11 combinationally in the cycle after cfg_done.
- Old config persists: during LOAD the lane0 output still follows the AND/OR mapping; it switches only after COMMIT.
- cfg_valid gaps of 3 cycles every other bit → same final config as a gapless load; cfg_done occurs exactly once.
- cfg_start after 7 bits → cfg_err pulses; a subsequent full 20-bit load commits correctly. clr_n asserted after 10 bits → active config reverts to default and cfg_ready=0.
- WIDTH=8, ce toggled → register holds while ce=0; bypass lanes track mux_out while ce=0.
